// File: rtl/mcac_cu_pkg.sv
// Shared definitions for the mcac_sr multi-channel control unit.
//   - cu_state_e : sequencer FSM state encoding
//   - DEF_*      : default channel/step/watchdog sizing
package mcac_cu_pkg;

  localparam int DEF_NUM_CH    = 32;
  localparam int DEF_CH_W      = 5;
  localparam int DEF_NUM_STEPS = 8;
  localparam int DEF_STEP_W    = 3;
  localparam int DEF_WDOG      = 255;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SCAN  = 3'd1,
    ST_LOAD  = 3'd2,
    ST_START = 3'd3,
    ST_WAIT  = 3'd4,
    ST_STORE = 3'd5
  } cu_state_e;

endpackage

// File: rtl/cu_wdog_cnt.sv
// Watchdog counter for datapath step completion.
//   clk, reset : clock, synchronous active-high reset
//   clr        : zero the count (takes priority over en)
//   en         : count one cycle of waiting
//   expire     : high in the WDOG-th consecutive enabled cycle after a clear
module cu_wdog_cnt #(
  parameter int WDOG = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CW = (WDOG < 1) ? 1 : $clog2(WDOG + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Saturates at WDOG so a stalled waiter cannot wrap and re-fire.
  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (en && (cnt_q != CW'(WDOG)))
      cnt_d = cnt_q + CW'(1);
  end

  // Fires on the cycle that would bring the count to WDOG, so the
  // caller can act in the same cycle as the final wait cycle.
  assign expire = en && !clr && (cnt_q == CW'(WDOG - 1));

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/cu_mchan_seq.sv
// Multi-channel control unit for the mcac_sr codec. Each frame_sync walks
// all channels enabled at frame start; for each: load state, run NUM_STEPS
// datapath steps, store state. Detects overrun and datapath stalls.
//   clk, reset            : clock, synchronous active-high reset
//   scan_in0/scan_enable  : DFT scan hooks, unused functionally
//   scan_out0             : DFT scan output, tied low in RTL
//   frame_sync            : start-of-frame pulse
//   ch_en, ch_mode        : per-channel enable / mode (1 = decode), sampled at frame start
//   dp_done               : datapath step complete
//   clr_err               : clear sticky error flags
//   ch_idx, step, mode    : current channel, step, channel mode
//   st_rd, st_wr          : state-memory read/write strobes
//   dp_start              : datapath step start pulse
//   busy                  : frame in progress
//   err_ovr, err_wdog     : sticky overrun / watchdog flags
module cu_mchan_seq
  import mcac_cu_pkg::*;
#(
  parameter int NUM_CH    = DEF_NUM_CH,
  parameter int CH_W      = DEF_CH_W,
  parameter int NUM_STEPS = DEF_NUM_STEPS,
  parameter int STEP_W    = DEF_STEP_W,
  parameter int WDOG      = DEF_WDOG
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              scan_in0,
  input  logic              scan_enable,
  output logic              scan_out0,
  input  logic              frame_sync,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic [NUM_CH-1:0] ch_mode,
  input  logic              dp_done,
  input  logic              clr_err,
  output logic [CH_W-1:0]   ch_idx,
  output logic [STEP_W-1:0] step,
  output logic              mode,
  output logic              st_rd,
  output logic              st_wr,
  output logic              dp_start,
  output logic              busy,
  output logic              err_ovr,
  output logic              err_wdog
);

  cu_state_e         state_q, state_d;
  logic [CH_W-1:0]   ch_idx_q, ch_idx_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic              mode_q, mode_d;
  logic [NUM_CH-1:0] en_mask_q, en_mask_d;
  logic [NUM_CH-1:0] mode_mask_q, mode_mask_d;
  logic              st_rd_q, st_rd_d;
  logic              st_wr_q, st_wr_d;
  logic              dp_start_q, dp_start_d;
  logic              busy_q, busy_d;
  logic              err_ovr_q, err_ovr_d;
  logic              err_wdog_q, err_wdog_d;

  logic wdog_expire;
  logic wdog_set;
  logic last_ch;
  logic last_step;
  logic unused_scan;

  assign unused_scan = scan_in0 ^ scan_enable;
  assign scan_out0   = 1'b0;

  cu_wdog_cnt #(.WDOG(WDOG)) u_wdog (
    .clk    (clk),
    .reset  (reset),
    .clr    (state_q == ST_START),
    .en     (state_q == ST_WAIT),
    .expire (wdog_expire)
  );

  assign last_ch   = (ch_idx_q == CH_W'(NUM_CH - 1));
  assign last_step = (step_q == STEP_W'(NUM_STEPS - 1));

  always_comb begin
    state_d     = state_q;
    ch_idx_d    = ch_idx_q;
    step_d      = step_q;
    mode_d      = mode_q;
    en_mask_d   = en_mask_q;
    mode_mask_d = mode_mask_q;
    wdog_set    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (frame_sync) begin
          en_mask_d   = ch_en;
          mode_mask_d = ch_mode;
          ch_idx_d    = '0;
          state_d     = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (en_mask_q[ch_idx_q]) begin
          mode_d  = mode_mask_q[ch_idx_q];
          step_d  = '0;
          state_d = ST_LOAD;
        end else if (last_ch) begin
          state_d = ST_IDLE;
        end else begin
          ch_idx_d = ch_idx_q + CH_W'(1);
        end
      end
      ST_LOAD:  state_d = ST_START;
      ST_START: state_d = ST_WAIT;
      ST_WAIT: begin
        // dp_done is checked first so a completion on the expiry cycle wins.
        if (dp_done) begin
          if (last_step) begin
            state_d = ST_STORE;
          end else begin
            step_d  = step_q + STEP_W'(1);
            state_d = ST_START;
          end
        end else if (wdog_expire) begin
          // Abandon the channel without writing back its state.
          wdog_set = 1'b1;
          if (last_ch) begin
            state_d = ST_IDLE;
          end else begin
            ch_idx_d = ch_idx_q + CH_W'(1);
            state_d  = ST_SCAN;
          end
        end
      end
      ST_STORE: begin
        if (last_ch) begin
          state_d = ST_IDLE;
        end else begin
          ch_idx_d = ch_idx_q + CH_W'(1);
          state_d  = ST_SCAN;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Strobes are registered from the next state, so each is high exactly
    // during the cycle the FSM sits in the corresponding state.
    st_rd_d    = (state_d == ST_LOAD);
    st_wr_d    = (state_d == ST_STORE);
    dp_start_d = (state_d == ST_START);
    busy_d     = (state_d != ST_IDLE);

    // Sticky flags: a set in the same cycle as clr_err survives.
    err_ovr_d  = (clr_err ? 1'b0 : err_ovr_q)
               | (frame_sync && (state_q != ST_IDLE));
    err_wdog_d = (clr_err ? 1'b0 : err_wdog_q) | wdog_set;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      ch_idx_q    <= '0;
      step_q      <= '0;
      mode_q      <= 1'b0;
      en_mask_q   <= '0;
      mode_mask_q <= '0;
      st_rd_q     <= 1'b0;
      st_wr_q     <= 1'b0;
      dp_start_q  <= 1'b0;
      busy_q      <= 1'b0;
      err_ovr_q   <= 1'b0;
      err_wdog_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ch_idx_q    <= ch_idx_d;
      step_q      <= step_d;
      mode_q      <= mode_d;
      en_mask_q   <= en_mask_d;
      mode_mask_q <= mode_mask_d;
      st_rd_q     <= st_rd_d;
      st_wr_q     <= st_wr_d;
      dp_start_q  <= dp_start_d;
      busy_q      <= busy_d;
      err_ovr_q   <= err_ovr_d;
      err_wdog_q  <= err_wdog_d;
    end
  end

  assign ch_idx   = ch_idx_q;
  assign step     = step_q;
  assign mode     = mode_q;
  assign st_rd    = st_rd_q;
  assign st_wr    = st_wr_q;
  assign dp_start = dp_start_q;
  assign busy     = busy_q;
  assign err_ovr  = err_ovr_q;
  assign err_wdog = err_wdog_q;

endmodule

// File: tb/tb_cu_mchan_seq.sv
// Directed bench for cu_mchan_seq (NUM_CH=32, NUM_STEPS=8, WDOG=4).
// A per-frame runner drives frame_sync and answers each dp_start with
// dp_done two cycles later, logging strobes; each test task checks the log.
module tb_cu_mchan_seq;

  logic        clk = 1'b0;
  logic        reset, scan_in0, scan_enable, scan_out0;
  logic        frame_sync, dp_done, clr_err;
  logic [31:0] ch_en, ch_mode;
  logic [4:0]  ch_idx;
  logic [2:0]  step;
  logic        mode, st_rd, st_wr, dp_start, busy, err_ovr, err_wdog;

  int checks = 0;
  int errors = 0;

  // frame log
  int rd_q[$], wr_q[$], md_q[$], stp_q[$], sch_q[$], rd_cyc_q[$];
  int busy_cyc, hold_cyc, wdog_cyc, first_ch;
  bit timeout;

  cu_mchan_seq #(.NUM_CH(32), .CH_W(5), .NUM_STEPS(8), .STEP_W(3), .WDOG(4)) dut (
    .clk(clk), .reset(reset), .scan_in0(scan_in0), .scan_enable(scan_enable),
    .scan_out0(scan_out0), .frame_sync(frame_sync), .ch_en(ch_en), .ch_mode(ch_mode),
    .dp_done(dp_done), .clr_err(clr_err), .ch_idx(ch_idx), .step(step), .mode(mode),
    .st_rd(st_rd), .st_wr(st_wr), .dp_start(dp_start), .busy(busy),
    .err_ovr(err_ovr), .err_wdog(err_wdog)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Runs one frame to completion. ovr_at: cycle to re-pulse frame_sync (-1 none).
  // hold_ch/hold_step: step whose dp_done is withheld (-1 none).
  task automatic run_frame(input logic [31:0] en, input logic [31:0] md,
                           input int ovr_at, input int hold_ch, input int hold_step);
    int dly, cyc;
    rd_q.delete(); wr_q.delete(); md_q.delete(); stp_q.delete(); sch_q.delete();
    rd_cyc_q.delete();
    busy_cyc = 0; hold_cyc = -1; wdog_cyc = -1; timeout = 0;
    ch_en = en; ch_mode = md; frame_sync = 1'b1;
    tick;
    frame_sync = 1'b0;
    first_ch = int'(ch_idx);
    dly = 0; cyc = 0;
    while (busy === 1'b1 && cyc < 3000) begin
      busy_cyc++;
      if (st_rd) begin
        rd_q.push_back(int'(ch_idx)); md_q.push_back(int'(mode)); rd_cyc_q.push_back(cyc);
      end
      if (st_wr) wr_q.push_back(int'(ch_idx));
      if (err_wdog && wdog_cyc < 0) wdog_cyc = cyc;
      dp_done = 1'b0;
      if (dly > 0) begin
        dly--;
        if (dly == 0) dp_done = 1'b1;
      end
      if (dp_start) begin
        stp_q.push_back(int'(step)); sch_q.push_back(int'(ch_idx));
        if (int'(ch_idx) == hold_ch && int'(step) == hold_step) hold_cyc = cyc;
        else dly = 2;
      end
      frame_sync = (cyc == ovr_at);
      tick;
      cyc++;
    end
    frame_sync = 1'b0; dp_done = 1'b0;
    if (cyc >= 3000) timeout = 1;
  endtask

  task automatic test_reset;
    reset = 1'b1; tick; tick;
    checks++;
    if ({busy, st_rd, st_wr, dp_start, mode, err_ovr, err_wdog, scan_out0} !== 8'h00 ||
        ch_idx !== 5'd0 || step !== 3'd0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b rd=%b wr=%b start=%b ch=%0d step=%0d need all 0",
               busy, st_rd, st_wr, dp_start, ch_idx, step);
    end
    reset = 1'b0; tick;
  endtask

  task automatic test_no_channels;
    run_frame(32'h0, 32'h0, -1, -1, -1);
    checks++;
    if (timeout || busy_cyc != 32) begin
      errors++; $display("FAIL empty_busy_cycles: got %0d need 32", busy_cyc);
    end
    checks++;
    if (rd_q.size() != 0 || wr_q.size() != 0 || stp_q.size() != 0) begin
      errors++;
      $display("FAIL empty_strobes: rd=%0d wr=%0d start=%0d need 0",
               rd_q.size(), wr_q.size(), stp_q.size());
    end
  endtask

  task automatic test_single_channel;
    bit bad;
    run_frame(32'h1, 32'h1, -1, -1, -1);
    checks++;
    if (timeout || busy_cyc != 58) begin
      errors++; $display("FAIL single_busy_cycles: got %0d need 58", busy_cyc);
    end
    checks++;
    if (rd_q.size() != 1 || rd_q[0] != 0 || md_q[0] != 1) begin
      errors++; $display("FAIL single_load: rd count %0d need 1 at ch0 mode1", rd_q.size());
    end
    checks++;
    if (wr_q.size() != 1 || wr_q[0] != 0) begin
      errors++; $display("FAIL single_store: wr count %0d need 1 at ch0", wr_q.size());
    end
    bad = (stp_q.size() != 8);
    if (!bad) for (int i = 0; i < 8; i++) if (stp_q[i] != i || sch_q[i] != 0) bad = 1;
    checks++;
    if (bad) begin
      errors++; $display("FAIL single_steps: %0d starts, need steps 0..7 on ch0", stp_q.size());
    end
  endtask

  task automatic test_skip;
    int exp_ch[3] = '{0, 2, 31};
    int exp_md[3] = '{0, 1, 0};
    bit bad;
    run_frame(32'h8000_0005, 32'h0000_0004, -1, -1, -1);
    checks++;
    if (timeout || busy_cyc != 110) begin
      errors++; $display("FAIL skip_busy_cycles: got %0d need 110", busy_cyc);
    end
    bad = (rd_q.size() != 3 || wr_q.size() != 3);
    if (!bad) for (int i = 0; i < 3; i++)
      if (rd_q[i] != exp_ch[i] || wr_q[i] != exp_ch[i] || md_q[i] != exp_md[i]) bad = 1;
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL skip_order: rd=%0d wr=%0d entries, need ch 0,2,31 modes 0,1,0",
               rd_q.size(), wr_q.size());
    end
    checks++;
    if (stp_q.size() != 24) begin
      errors++; $display("FAIL skip_starts: got %0d need 24", stp_q.size());
    end
  endtask

  task automatic test_overrun;
    run_frame(32'h5, 32'h0, 5, -1, -1);
    checks++;
    if (timeout || busy_cyc != 84 || rd_q.size() != 2 || wr_q.size() != 2) begin
      errors++;
      $display("FAIL ovr_sequence: busy=%0d rd=%0d wr=%0d need 84/2/2",
               busy_cyc, rd_q.size(), wr_q.size());
    end
    checks++;
    if (err_ovr !== 1'b1 || err_wdog !== 1'b0) begin
      errors++; $display("FAIL ovr_flag: err_ovr=%b err_wdog=%b need 1/0", err_ovr, err_wdog);
    end
    clr_err = 1'b1; tick; clr_err = 1'b0;
    checks++;
    if (err_ovr !== 1'b0) begin
      errors++; $display("FAIL ovr_clear: err_ovr=%b need 0", err_ovr);
    end
  endtask

  task automatic test_watchdog;
    run_frame(32'h18, 32'h0, -1, 3, 2);
    checks++;
    if (timeout || busy_cyc != 70) begin
      errors++; $display("FAIL wdog_busy_cycles: got %0d need 70", busy_cyc);
    end
    checks++;
    if (err_wdog !== 1'b1 || hold_cyc < 0 || wdog_cyc - hold_cyc != 5) begin
      errors++;
      $display("FAIL wdog_timing: err_wdog=%b rise %0d cycles after start, need 1 and 5",
               err_wdog, wdog_cyc - hold_cyc);
    end
    checks++;
    if (wr_q.size() != 1 || wr_q[0] != 4) begin
      errors++; $display("FAIL wdog_no_store: wr count %0d need one at ch4", wr_q.size());
    end
    checks++;
    if (rd_q.size() != 2 || rd_q[1] != 4 || rd_cyc_q[1] != hold_cyc + 6) begin
      errors++; $display("FAIL wdog_next_load: rd count %0d need ch4 LOAD 6 cycles after start",
                         rd_q.size());
    end
  endtask

  task automatic test_reset_mid_frame;
    int n;
    ch_en = 32'h1; ch_mode = 32'h1; frame_sync = 1'b1;
    tick;
    frame_sync = 1'b0;
    n = 0;
    while (dp_start !== 1'b1 && n < 50) begin tick; n++; end
    checks++;
    if (dp_start !== 1'b1) begin
      errors++; $display("FAIL midreset_reach_start: dp_start=%b need 1", dp_start);
    end
    tick;
    reset = 1'b1; tick; reset = 1'b0;
    checks++;
    if ({busy, st_rd, st_wr, dp_start, mode, err_ovr, err_wdog} !== 7'h00 ||
        ch_idx !== 5'd0 || step !== 3'd0) begin
      errors++;
      $display("FAIL midreset_outputs: busy=%b wr=%b mode=%b wdog=%b ch=%0d need all 0",
               busy, st_wr, mode, err_wdog, ch_idx);
    end
    tick;
    checks++;
    if (busy !== 1'b0 || st_wr !== 1'b0) begin
      errors++; $display("FAIL midreset_idle: busy=%b st_wr=%b need 0/0", busy, st_wr);
    end
    run_frame(32'h2, 32'h0, -1, -1, -1);
    checks++;
    if (timeout || first_ch != 0 || rd_q.size() != 1 || rd_q[0] != 1 ||
        wr_q.size() != 1 || wr_q[0] != 1) begin
      errors++;
      $display("FAIL midreset_restart: first ch %0d rd=%0d wr=%0d need ch0 start, one ch1 rd/wr",
               first_ch, rd_q.size(), wr_q.size());
    end
  endtask

  initial begin
    reset = 1'b1; scan_in0 = 1'b0; scan_enable = 1'b0; frame_sync = 1'b0;
    dp_done = 1'b0; clr_err = 1'b0; ch_en = '0; ch_mode = '0;
    test_reset;
    test_no_channels;
    test_single_channel;
    test_skip;
    test_overrun;
    test_watchdog;
    test_reset_mid_frame;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
